// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back, write-allocate sequencer between a CPU port, a
// direct-mapped cache array (same-cycle lookup) and a line-wide memory port.
// Misses go through optional write-back of a dirty victim, a line fill, and
// a single cache update cycle, after which the CPU request is retried.
module cache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic             re,
  input  logic             we,
  input  logic [15:0]      wr_data,
  output logic [15:0]      rd_data,
  output logic             stall,
  output logic [13:0]      c_addr,
  output logic             c_re,
  output logic             c_we,
  output logic             c_wdirty,
  output logic [63:0]      c_wr_data,
  input  logic [63:0]      c_rd_data,
  input  logic [7:0]       c_tag_out,
  input  logic             c_hit,
  input  logic             c_dirty,
  output logic [13:0]      m_addr,
  output logic             m_re,
  output logic             m_we,
  output logic [63:0]      m_wr_data,
  input  logic [63:0]      m_rd_data,
  input  logic             m_rdy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, WB, FILL, UPDATE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] victim_buf;
  logic [7:0]  victim_tag;
  logic [63:0] fill_buf;
  logic        retry;
  logic        req;
  logic        idle_hit;
  logic        idle_miss;
  logic [1:0]  word_sel;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Select one 16-bit word of a 64-bit line; word 0 is bits [15:0].
  function automatic logic [15:0] get_word(input logic [63:0] line,
                                           input logic [1:0]  sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  // Replace one 16-bit word of a 64-bit line.
  function automatic logic [63:0] merge_word(input logic [63:0] line,
                                             input logic [1:0]  sel,
                                             input logic [15:0] w);
    logic [63:0] r;
    r = line;
    r[{sel, 4'b0000} +: 16] = w;
    return r;
  endfunction

  // A simultaneous read and write is a write; any request opens a lookup.
  assign req       = re | we;
  assign idle_hit  = (state == IDLE) & req & c_hit;
  assign idle_miss = (state == IDLE) & req & ~c_hit;
  assign word_sel  = addr[1:0];

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: m_rdy only matters while a memory transaction is open.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (idle_miss) state_nxt = c_dirty ? WB : FILL;
      WB:      if (m_rdy) state_nxt = FILL;
      FILL:    if (m_rdy) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: cache lookup in IDLE, memory traffic in WB/FILL, line install in UPDATE.
  always_comb begin
    c_addr    = addr[15:2];
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_wdirty  = 1'b0;
    c_wr_data = merge_word(c_rd_data, word_sel, wr_data);
    m_addr    = addr[15:2];
    m_re      = 1'b0;
    m_we      = 1'b0;
    m_wr_data = victim_buf;
    rd_data   = get_word(c_rd_data, word_sel);
    stall     = req & ~((state == IDLE) & c_hit);
    case (state)
      IDLE: begin
        c_re = req;
        if (idle_hit & we) begin
          c_we     = 1'b1;
          c_wdirty = 1'b1;
        end
      end
      WB: begin
        m_we   = 1'b1;
        m_addr = {victim_tag, addr[7:2]};
      end
      FILL: begin
        m_re = 1'b1;
      end
      UPDATE: begin
        c_we      = 1'b1;
        c_wr_data = fill_buf;
      end
      default: ;
    endcase
    // The cache clears itself during reset; never write it then.
    if (rst) c_we = 1'b0;
  end

  // Victim capture on a dirty miss, line capture at fill completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_buf <= '0;
      victim_tag <= '0;
      fill_buf   <= '0;
    end else begin
      if (idle_miss & c_dirty) begin
        victim_buf <= c_rd_data;
        victim_tag <= c_tag_out;
      end
      if ((state == FILL) & m_rdy) fill_buf <= m_rd_data;
    end
  end

  // Statistics: the hit that completes a retried miss is not a new hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      retry    <= 1'b0;
    end else begin
      if (idle_hit & ~retry) hit_cnt <= sat_inc(hit_cnt);
      if (idle_miss)         miss_cnt <= sat_inc(miss_cnt);
      if (state == UPDATE)    retry <= 1'b1;
      else if (state == IDLE) retry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scenarios against behavioural cache and memory
// models; CPU completions and memory completions are checked from queues.
`timescale 1ns/1ps
module tb_cache_ctrl;

  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic [15:0]      addr;
  logic             re;
  logic             we;
  logic [15:0]      wr_data;
  logic [15:0]      rd_data;
  logic             stall;
  logic [13:0]      c_addr;
  logic             c_re;
  logic             c_we;
  logic             c_wdirty;
  logic [63:0]      c_wr_data;
  logic [63:0]      c_rd_data;
  logic [7:0]       c_tag_out;
  logic             c_hit;
  logic             c_dirty;
  logic [13:0]      m_addr;
  logic             m_re;
  logic             m_we;
  logic [63:0]      m_wr_data;
  logic [63:0]      m_rd_data;
  logic             m_rdy;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  cache_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wr_data(wr_data),
    .rd_data(rd_data), .stall(stall), .c_addr(c_addr), .c_re(c_re),
    .c_we(c_we), .c_wdirty(c_wdirty), .c_wr_data(c_wr_data),
    .c_rd_data(c_rd_data), .c_tag_out(c_tag_out), .c_hit(c_hit),
    .c_dirty(c_dirty), .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_rdy(m_rdy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct { logic is_rd; logic [15:0] rd; int stalls; string name; } cpu_exp_t;
  typedef struct { logic wr; logic [13:0] a; logic [63:0] d; string name; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- cache array model (direct mapped, 64 lines) ----------
  logic        cache_clr;
  logic        cv [0:63];
  logic        cd [0:63];
  logic [7:0]  ct [0:63];
  logic [63:0] cl [0:63];
  logic [5:0]  cidx;

  assign cidx      = c_addr[5:0];
  assign c_hit     = cv[cidx] && (ct[cidx] == c_addr[13:6]);
  assign c_tag_out = ct[cidx];
  assign c_dirty   = cv[cidx] && cd[cidx];
  assign c_rd_data = cl[cidx];

  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 64; i++) begin
        cv[i] <= 1'b0; cd[i] <= 1'b0; ct[i] <= 8'h00; cl[i] <= 64'h0;
      end
    end else if (c_we) begin
      cv[cidx] <= 1'b1;
      cd[cidx] <= c_wdirty;
      ct[cidx] <= c_addr[13:6];
      cl[cidx] <= c_wr_data;
    end
  end

  // ---------------- memory model: completion Lw/Lf cycles after request --
  logic [63:0] mem [0:16383];
  logic        mem_auto;
  logic        force_rdy;
  int          lat_w;
  int          lat_f;

  initial begin
    int mcnt;
    for (int i = 0; i < 16384; i++) mem[i] = 64'h0;
    mem[14'h048D] = 64'hDDDD_CCCC_BBBB_AAAA;
    mem[14'h0D0D] = 64'h4444_3333_2222_1111;
    mem[14'h1580] = 64'h0123_4567_89AB_CDEF;
    m_rdy = 1'b0;
    m_rd_data = 64'h0;
    mcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_auto) begin
        m_rdy = force_rdy;
        mcnt = 0;
      end else if (!rst && (m_re || m_we)) begin
        m_rdy = (mcnt == ((m_we ? lat_w : lat_f) - 1));
        mcnt = m_rdy ? 0 : mcnt + 1;
        if (m_rdy && m_we) mem[m_addr] = m_wr_data;
      end else begin
        m_rdy = 1'b0;
        mcnt = 0;
      end
      m_rd_data = mem[m_addr];
    end
  end

  // ---------------- CPU-side monitor -------------------------------------
  initial begin
    int sc;
    cpu_exp_t e;
    sc = 0;
    forever begin
      @(negedge clk);
      if (rst || !(re || we)) begin
        sc = 0;
      end else if (stall) begin
        sc++;
      end else begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: completion at addr 0x%0h with nothing expected", addr);
        end else begin
          e = cpu_q.pop_front();
          chk({e.name, "/stall_cycles"}, 64'(sc), 64'(e.stalls));
          if (e.is_rd) chk({e.name, "/rd_data"}, 64'(rd_data), 64'(e.rd));
        end
        sc = 0;
      end
    end
  end

  // ---------------- memory-side monitor ----------------------------------
  initial begin
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_rdy && (m_re || m_we)) begin
        chk("mem_excl", 64'(m_re & m_we), 64'd0);
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: m_addr 0x%0h m_we %0d with nothing expected", m_addr, m_we);
        end else begin
          e = mem_q.pop_front();
          chk({e.name, "/m_we"}, 64'(m_we), 64'(e.wr));
          chk({e.name, "/m_addr"}, 64'(m_addr), 64'(e.a));
          if (e.wr) chk({e.name, "/m_wr_data"}, m_wr_data, e.d);
        end
      end
    end
  end

  task automatic push_mem(input logic w, input logic [13:0] a, input logic [63:0] d,
                          input string nm);
    mem_exp_t e;
    e.wr = w; e.a = a; e.d = d; e.name = nm;
    mem_q.push_back(e);
  endtask

  // Issue one CPU request at posedge+1, wait for stall to drop, then release.
  task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd,
                        input int exp_stalls, input string nm);
    cpu_exp_t e;
    logic done;
    e.is_rd = r & ~w; e.rd = exp_rd; e.stalls = exp_stalls; e.name = nm;
    cpu_q.push_back(e);
    re = r; we = w; addr = a; wr_data = d;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s/timeout: stall still %0d after 60 cycles, expected release", nm, stall);
    end
    @(posedge clk);
    #1;
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios -----------------------------------
  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = 16'h0; wr_data = 16'h0;
    cache_clr = 1'b1; mem_auto = 1'b1; force_rdy = 1'b0; lat_w = 2; lat_f = 3;

    #1;
    chk("rst/stall", 64'(stall), 64'd0);
    chk("rst/m_re", 64'(m_re), 64'd0);
    chk("rst/m_we", 64'(m_we), 64'd0);
    chk("rst/c_we", 64'(c_we), 64'd0);
    chk("rst/hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst/miss_cnt", 64'(miss_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    cache_clr = 1'b0; rst = 1'b0;

    // Cold clean miss, Lf=3: stall Lf+2; 0x1234 selects word 0 (addr[1:0]=0).
    push_mem(1'b0, 14'h048D, 64'h0, "cold_fill");
    do_req(1'b1, 1'b0, 16'h1234, 16'h0, 16'hAAAA, 5, "cold_rd");
    chk("cold/miss_cnt", 64'(miss_cnt), 64'd1);
    chk("cold/hit_cnt", 64'(hit_cnt), 64'd0);

    do_req(1'b1, 1'b0, 16'h1234, 16'h0, 16'hAAAA, 0, "hit_rd");
    chk("hit/hit_cnt", 64'(hit_cnt), 64'd1);
    do_req(1'b1, 1'b0, 16'h1236, 16'h0, 16'hCCCC, 0, "hit_rd_w2");
    chk("hit2/hit_cnt", 64'(hit_cnt), 64'd2);

    // Write hit merges word 2 and marks the line dirty.
    do_req(1'b0, 1'b1, 16'h1236, 16'h5555, 16'h0, 0, "wr_hit");
    chk("wr_hit/line", cl[13], 64'hDDDD_5555_BBBB_AAAA);
    chk("wr_hit/dirty", 64'(cd[13]), 64'd1);
    chk("wr_hit/hit_cnt", 64'(hit_cnt), 64'd3);

    // Same index, tag 0x34: write back victim then fill; Lw=2, Lf=3 -> 7 stalls.
    push_mem(1'b1, 14'h048D, 64'hDDDD_5555_BBBB_AAAA, "victim_wb");
    push_mem(1'b0, 14'h0D0D, 64'h0, "dirty_fill");
    do_req(1'b1, 1'b0, 16'h3436, 16'h0, 16'h3333, 7, "dirty_miss");
    chk("dirty/mem_wb", mem[14'h048D], 64'hDDDD_5555_BBBB_AAAA);
    chk("dirty/miss_cnt", 64'(miss_cnt), 64'd2);
    chk("dirty/hit_cnt", 64'(hit_cnt), 64'd3);
    chk("dirty/line_tag", 64'(ct[13]), 64'h34);
    chk("dirty/line_clean", 64'(cd[13]), 64'd0);

    // re=we=1 on a hit behaves as a write to word 0.
    do_req(1'b1, 1'b1, 16'h3434, 16'h7777, 16'h0, 0, "rw_as_wr");
    chk("rw/line", cl[13], 64'h4444_3333_2222_7777);
    chk("rw/dirty", 64'(cd[13]), 64'd1);
    chk("rw/hit_cnt", 64'(hit_cnt), 64'd4);

    // Minimum latency clean miss: Lf=1 -> 3 stalls.
    lat_f = 1;
    push_mem(1'b0, 14'h1580, 64'h0, "fast_fill");
    do_req(1'b1, 1'b0, 16'h5600, 16'h0, 16'hCDEF, 3, "fast_fill_rd");
    chk("fast/miss_cnt", 64'(miss_cnt), 64'd3);

    // Write miss allocates, then merges word 3 on the retry.
    push_mem(1'b0, 14'h2682, 64'h0, "wmiss_fill");
    do_req(1'b0, 1'b1, 16'h9A0B, 16'hBEEF, 16'h0, 3, "wr_miss");
    chk("wmiss/line", cl[2], 64'hBEEF_0000_0000_0000);
    chk("wmiss/dirty", 64'(cd[2]), 64'd1);
    chk("wmiss/miss_cnt", 64'(miss_cnt), 64'd4);
    chk("wmiss/hit_cnt", 64'(hit_cnt), 64'd4);

    // Reset in the middle of a fill; the late m_rdy must be ignored.
    mem_auto = 1'b0; force_rdy = 1'b0; lat_f = 3;
    re = 1'b1; addr = 16'h7800;
    @(negedge clk);
    chk("midfill/stall", 64'(stall), 64'd1);
    @(negedge clk);
    chk("midfill/m_re", 64'(m_re), 64'd1);
    #1;
    rst = 1'b1; re = 1'b0; we = 1'b1; addr = 16'h5600; wr_data = 16'hFFFF;
    #1;
    chk("midfill_rst/m_re", 64'(m_re), 64'd0);
    chk("midfill_rst/m_we", 64'(m_we), 64'd0);
    chk("midfill_rst/c_we", 64'(c_we), 64'd0);
    chk("midfill_rst/hit_cnt", 64'(hit_cnt), 64'd0);
    chk("midfill_rst/miss_cnt", 64'(miss_cnt), 64'd0);
    force_rdy = 1'b1;
    @(posedge clk);
    #3;
    we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("late_rdy/m_rdy_seen", 64'(m_rdy), 64'd1);
    @(negedge clk);
    chk("late_rdy/m_re", 64'(m_re), 64'd0);
    chk("late_rdy/m_we", 64'(m_we), 64'd0);
    chk("late_rdy/c_we", 64'(c_we), 64'd0);
    chk("late_rdy/stall", 64'(stall), 64'd0);
    chk("late_rdy/miss_cnt", 64'(miss_cnt), 64'd0);
    force_rdy = 1'b0;
    @(posedge clk);
    #3;
    mem_auto = 1'b1;
    chk("no_cwrite/tag", 64'(ct[0]), 64'h56);
    chk("no_cwrite/line", cl[0], 64'h0123_4567_89AB_CDEF);
    chk("no_cwrite/dirty", 64'(cd[0]), 64'd0);
    @(posedge clk);
    #1;

    // Saturation with a 3-bit counter: six hits reach 6, more hits stop at 7.
    for (int i = 0; i < 6; i++)
      do_req(1'b1, 1'b0, 16'h5600, 16'h0, 16'hCDEF, 0, "sat_pre");
    chk("sat/hit_cnt_6", 64'(hit_cnt), 64'd6);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, 16'h5600, 16'h0, 16'hCDEF, 0, "sat_hit");
      chk("sat/hit_cnt_max", 64'(hit_cnt), 64'd7);
    end
    chk("sat/miss_cnt", 64'(miss_cnt), 64'd0);

    repeat (2) @(posedge clk);
    chk("cpu_q_empty", 64'(cpu_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
